// File: rtl/rom_bist_pkg.sv
// Shared FSM encoding and MISR constants for the ROM BIST controller.
package rom_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    CHECK,
    DONE
  } bist_state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

endpackage

// File: rtl/rom_bist_misr.sv
// Multiple-input signature register that folds ROM read data into a CRC-32 style signature.
module rom_bist_misr
  import rom_bist_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              seed,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sig
);

  logic [DATA_W-1:0] sig_q;
  logic [DATA_W-1:0] sig_d;
  logic [DATA_W-1:0] feedback;

  // Seeding wins over compression so a new run always starts from a known value.
  always_comb begin
    feedback = sig_q[DATA_W-1] ? DATA_W'(MISR_POLY) : '0;
    sig_d    = sig_q;
    if (seed) begin
      sig_d = DATA_W'(MISR_SEED);
    end else if (en) begin
      sig_d = {sig_q[DATA_W-2:0], 1'b0} ^ feedback ^ din;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/rom_bist_ctrl.sv
// ROM BIST controller: sweeps the whole ROM once, compresses the returned data
// into a MISR and compares the final signature with a golden value.
module rom_bist_ctrl
  import rom_bist_pkg::*;
#(
  parameter int                ADDR_W  = 11,
  parameter int                DATA_W  = 32,
  parameter int                RD_LAT  = 1,
  parameter logic [DATA_W-1:0] EXP_SIG = '0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              bist_en,
  input  logic              bist_start,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              rom_ren,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_pass,
  output logic [DATA_W-1:0] misr_sig
);

  logic [1:0]        rstSync_q;
  logic              rstSyncB;

  bist_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addrCnt_q, addrCnt_d;
  logic [1:0]        drainCnt_q, drainCnt_d;
  logic [RD_LAT-1:0] validPipe_q, validPipe_d;
  logic [RD_LAT-1:0] pipeShift;
  logic              startPrev_q;
  logic              pass_q, pass_d;
  logic              startEdge;
  logic              misrSeed;
  logic              flush;

  // Assertion is immediate through the async clear; release takes two clk edges,
  // which also keeps a start in the first cycle after release from being seen.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rstSync_q <= '0;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstSyncB = rstSync_q[1];

  assign rom_ren   = (state_q == READ);
  assign rom_addr  = rom_ren ? addrCnt_q : '0;
  assign bist_busy = (state_q == READ) || (state_q == DRAIN) || (state_q == CHECK);
  assign bist_done = (state_q == DONE);
  assign bist_pass = pass_q;
  assign startEdge = bist_start & ~startPrev_q;

  if (RD_LAT == 1) begin : g_pipe1
    assign pipeShift = rom_ren;
  end else begin : g_pipeN
    assign pipeShift = {validPipe_q[RD_LAT-2:0], rom_ren};
  end

  always_comb begin
    state_d    = state_q;
    addrCnt_d  = addrCnt_q;
    drainCnt_d = drainCnt_q;
    pass_d     = pass_q;
    misrSeed   = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      IDLE: begin
        pass_d    = 1'b0;
        addrCnt_d = '0;
        if (bist_en && startEdge) begin
          state_d  = READ;
          misrSeed = 1'b1;
        end
      end
      READ: begin
        if (!bist_en) begin
          state_d   = IDLE;
          flush     = 1'b1;
          addrCnt_d = '0;
        end else if (addrCnt_q == '1) begin
          state_d    = DRAIN;
          addrCnt_d  = '0;
          drainCnt_d = '0;
        end else begin
          addrCnt_d = addrCnt_q + 1'b1;
        end
      end
      // Hold off the compare until the last read has made it through the ROM.
      DRAIN: begin
        if (!bist_en) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (drainCnt_q == 2'(RD_LAT - 1)) begin
          state_d = CHECK;
        end else begin
          drainCnt_d = drainCnt_q + 2'd1;
        end
      end
      CHECK: begin
        if (!bist_en) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else begin
          pass_d  = (misr_sig == EXP_SIG);
          state_d = DONE;
        end
      end
      DONE: begin
        if (!bist_en) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    validPipe_d = flush ? '0 : pipeShift;
  end

  always_ff @(posedge clk or negedge rstSyncB) begin
    if (!rstSyncB) begin
      state_q     <= IDLE;
      addrCnt_q   <= '0;
      drainCnt_q  <= '0;
      validPipe_q <= '0;
      startPrev_q <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addrCnt_q   <= addrCnt_d;
      drainCnt_q  <= drainCnt_d;
      validPipe_q <= validPipe_d;
      startPrev_q <= bist_start;
      pass_q      <= pass_d;
    end
  end

  rom_bist_misr #(
    .DATA_W (DATA_W)
  ) u_misr (
    .clk  (clk),
    .rstb (rstSyncB),
    .seed (misrSeed),
    .en   (validPipe_q[RD_LAT-1]),
    .din  (rom_rdata),
    .sig  (misr_sig)
  );

endmodule

// File: tb/tb_rom_bist_ctrl.sv
// Directed bench for rom_bist_ctrl: a table of cycle vectors for the start handshake,
// then full ROM sweeps at read latency 1 and 3 against a behavioural ROM and MISR model.
module tb_rom_bist_ctrl;

  localparam int          ADDR_W   = 11;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] GOLD_SIG = 32'h5A17_C3E9;
  localparam logic [31:0] POLY     = 32'h04C1_1DB7;
  localparam int          NVEC     = 12;

  logic              clk = 1'b0;
  logic              rstb;
  logic              tbEn;
  logic              tbStart;
  logic              sel;

  logic              en1, start1, ren1, busy1, done1, pass1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] rd1, sig1;
  logic              en3, start3, ren3, busy3, done3, pass3;
  logic [ADDR_W-1:0] addr3;
  logic [DATA_W-1:0] sig3, p3a, p3b, p3c;

  logic              oRen, oBusy, oDone, oPass;
  logic [ADDR_W-1:0] oAddr;
  logic [DATA_W-1:0] oSig;

  logic [31:0]       mem [DEPTH];

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic              en;
    logic              start;
    logic              expRen;
    logic [ADDR_W-1:0] expAddr;
    logic              expBusy;
    logic              expDone;
    logic              expPass;
  } vec_t;

  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  assign en1    = tbEn & ~sel;
  assign start1 = tbStart & ~sel;
  assign en3    = tbEn & sel;
  assign start3 = tbStart & sel;

  assign oRen  = sel ? ren3  : ren1;
  assign oAddr = sel ? addr3 : addr1;
  assign oBusy = sel ? busy3 : busy1;
  assign oDone = sel ? done3 : done1;
  assign oPass = sel ? pass3 : pass1;
  assign oSig  = sel ? sig3  : sig1;

  // Behavioural ROMs: one cycle of latency for dut1, three for dut3.
  always @(posedge clk) begin
    rd1 <= ren1 ? mem[addr1] : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    p3a <= ren3 ? mem[addr3] : 32'hDEAD_BEEF;
    p3b <= p3a;
    p3c <= p3b;
  end

  rom_bist_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (1),
    .EXP_SIG (GOLD_SIG)
  ) dut1 (
    .clk        (clk),
    .rstb       (rstb),
    .bist_en    (en1),
    .bist_start (start1),
    .rom_rdata  (rd1),
    .rom_ren    (ren1),
    .rom_addr   (addr1),
    .bist_busy  (busy1),
    .bist_done  (done1),
    .bist_pass  (pass1),
    .misr_sig   (sig1)
  );

  rom_bist_ctrl #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (3),
    .EXP_SIG (GOLD_SIG)
  ) dut3 (
    .clk        (clk),
    .rstb       (rstb),
    .bist_en    (en3),
    .bist_start (start3),
    .rom_rdata  (p3c),
    .rom_ren    (ren3),
    .rom_addr   (addr3),
    .bist_busy  (busy3),
    .bist_done  (done3),
    .bist_pass  (pass3),
    .misr_sig   (sig3)
  );

  function automatic logic [31:0] misrStep(input logic [31:0] m, input logic [31:0] d);
    return {m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0) ^ d;
  endfunction

  function automatic logic [31:0] modelSig();
    logic [31:0] m;
    m = 32'hFFFF_FFFF;
    for (int a = 0; a < DEPTH; a++) m = misrStep(m, mem[a]);
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic start);
    tbEn    = en;
    tbStart = start;
    tick();
  endtask

  task automatic setVec(input int i, input logic en, input logic start, input logic ren,
                        input int addr, input logic busy, input logic done, input logic pass);
    vecs[i] = {en, start, ren, ADDR_W'(addr), busy, done, pass};
  endtask

  // One complete run from a start pulse through DONE and back to IDLE.
  task automatic runCheck(input string tag, input int lat, input logic expPass,
                          input logic [31:0] expSig, input bit poke);
    int doneCyc;
    int readErr;
    int phaseErr;
    int holdErr;
    doneCyc  = DEPTH + lat + 2;
    readErr  = 0;
    phaseErr = 0;
    holdErr  = 0;
    tbEn     = 1'b1;
    tbStart  = 1'b1;
    for (int k = 1; k <= doneCyc + 4; k++) begin
      tick();
      tbStart = poke && (k == 100 || k == doneCyc + 1);
      if (k == 1) checkOutput({tag, " seed"}, oSig, 32'hFFFF_FFFF);
      if (k <= DEPTH) begin
        if (oRen !== 1'b1 || oAddr !== ADDR_W'(k - 1) || oBusy !== 1'b1 || oDone !== 1'b0)
          readErr++;
      end else if (k < doneCyc) begin
        if (oRen !== 1'b0 || oAddr !== '0 || oBusy !== 1'b1 || oDone !== 1'b0)
          phaseErr++;
      end else begin
        if (oDone !== 1'b1 || oBusy !== 1'b0 || oRen !== 1'b0 || oPass !== expPass)
          holdErr++;
      end
      if (k == doneCyc) begin
        checkOutput({tag, " done rise"}, oDone, 1);
        checkOutput({tag, " pass"}, oPass, expPass);
        checkOutput({tag, " signature"}, oSig, expSig);
      end
    end
    checkOutput({tag, " read sweep errors"}, readErr, 0);
    checkOutput({tag, " drain/check errors"}, phaseErr, 0);
    checkOutput({tag, " done hold errors"}, holdErr, 0);
    tbStart = 1'b0;
    tbEn    = 1'b0;
    tick();
    checkOutput({tag, " exit done"}, oDone, 0);
    checkOutput({tag, " exit pass"}, oPass, 0);
    checkOutput({tag, " exit busy"}, oBusy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] m;
    logic [31:0] badSig;
    int          idleErr;

    // ROM image whose last word steers the signature onto GOLD_SIG.
    m = 32'hFFFF_FFFF;
    for (int a = 0; a < DEPTH - 1; a++) begin
      mem[a] = (32'(a) * 32'h9E37_79B9) ^ 32'h1234_5678;
      m      = misrStep(m, mem[a]);
    end
    mem[DEPTH-1] = misrStep(m, 32'h0) ^ GOLD_SIG;

    setVec(0,  0, 0, 0, 0, 0, 0, 0);
    setVec(1,  0, 1, 0, 0, 0, 0, 0);
    setVec(2,  1, 1, 0, 0, 0, 0, 0);
    setVec(3,  1, 0, 0, 0, 0, 0, 0);
    setVec(4,  1, 1, 1, 0, 1, 0, 0);
    setVec(5,  1, 0, 1, 1, 1, 0, 0);
    setVec(6,  1, 1, 1, 2, 1, 0, 0);
    setVec(7,  1, 0, 1, 3, 1, 0, 0);
    setVec(8,  0, 0, 0, 0, 0, 0, 0);
    setVec(9,  1, 0, 0, 0, 0, 0, 0);
    setVec(10, 1, 1, 1, 0, 1, 0, 0);
    setVec(11, 0, 0, 0, 0, 0, 0, 0);

    rstb    = 1'b0;
    tbEn    = 1'b0;
    tbStart = 1'b0;
    sel     = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    checkOutput("reset ren", ren1, 0);
    checkOutput("reset addr", 32'(addr1), 0);
    checkOutput("reset busy", busy1, 0);
    checkOutput("reset done", done1, 0);
    checkOutput("reset pass", pass1, 0);
    checkOutput("reset misr", sig1, 0);
    rstb = 1'b1;
    repeat (4) tick();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].en, vecs[i].start);
      checkOutput($sformatf("vec%0d ren", i), oRen, vecs[i].expRen);
      checkOutput($sformatf("vec%0d addr", i), 32'(oAddr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d busy", i), oBusy, vecs[i].expBusy);
      checkOutput($sformatf("vec%0d done", i), oDone, vecs[i].expDone);
      checkOutput($sformatf("vec%0d pass", i), oPass, vecs[i].expPass);
    end
    tick();

    runCheck("good lat1", 1, 1'b1, GOLD_SIG, 1'b0);
    tick();

    mem[1000] = mem[1000] ^ 32'h1;
    badSig    = modelSig();
    runCheck("corrupt lat1", 1, 1'b0, badSig, 1'b0);
    checkOutput("corrupt sig differs from golden", 32'(sig1 != GOLD_SIG), 1);
    mem[1000] = mem[1000] ^ 32'h1;
    tick();

    tbEn    = 1'b1;
    tbStart = 1'b1;
    for (int k = 1; k <= 501; k++) begin
      tick();
      tbStart = 1'b0;
    end
    checkOutput("abort addr before drop", 32'(oAddr), 500);
    tbEn = 1'b0;
    tick();
    checkOutput("abort ren", oRen, 0);
    checkOutput("abort addr", 32'(oAddr), 0);
    checkOutput("abort busy", oBusy, 0);
    checkOutput("abort done", oDone, 0);
    checkOutput("abort pass", oPass, 0);
    tick();
    runCheck("rerun lat1", 1, 1'b1, GOLD_SIG, 1'b0);
    tick();

    sel = 1'b1;
    tick();
    runCheck("good lat3", 3, 1'b1, GOLD_SIG, 1'b0);
    tick();

    // Reset while dut3 is in its first DRAIN cycle.
    tbEn    = 1'b1;
    tbStart = 1'b1;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick();
      tbStart = 1'b0;
    end
    checkOutput("pre-reset in drain busy", busy3, 1);
    checkOutput("pre-reset in drain ren", ren3, 0);
    #2 rstb = 1'b0;
    #1;
    checkOutput("async reset ren", ren3, 0);
    checkOutput("async reset addr", 32'(addr3), 0);
    checkOutput("async reset busy", busy3, 0);
    checkOutput("async reset done", done3, 0);
    checkOutput("async reset pass", pass3, 0);
    checkOutput("async reset misr", sig3, 0);
    @(negedge clk);
    rstb    = 1'b1;
    tbStart = 1'b1;
    tick();
    tbStart = 1'b0;
    idleErr = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (busy3 !== 1'b0 || ren3 !== 1'b0) idleErr++;
    end
    checkOutput("start after reset release ignored", idleErr, 0);
    tbEn = 1'b0;
    tick();
    runCheck("post-reset lat3", 3, 1'b1, GOLD_SIG, 1'b0);

    sel = 1'b0;
    tick();
    runCheck("extra starts lat1", 1, 1'b1, GOLD_SIG, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rom_bist_ctrl.md
ROM_BIST_CTRL -- requirements
Module: rom_bist_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, ROM address width (2048 words).
REQ-002 Parameter DATA_W, default 32, ROM read-data width.
REQ-003 Parameter RD_LAT, default 1, ROM read latency in clk cycles; legal range 1..3.
REQ-004 Parameter EXP_SIG, default 32'h0, golden MISR signature of the ROM image.
REQ-005 clk  input  1  single functional clock; all state on its rising edge.
REQ-006 rstb  input  1  asynchronous, active-low reset.
REQ-007 bist_en  input  1  BIST mode enable, already synchronized to clk upstream; level.
REQ-008 bist_start  input  1  run request; rising edge sampled in clk domain.
REQ-009 rom_rdata  input  DATA_W  ROM read data, valid RD_LAT cycles after rom_ren.
REQ-010 rom_ren  output  1  ROM read enable.
REQ-011 rom_addr  output  ADDR_W  ROM read address.
REQ-012 bist_busy  output  1  run in progress.
REQ-013 bist_done  output  1  run complete, result valid.
REQ-014 bist_pass  output  1  final signature equals EXP_SIG; meaningful only when bist_done=1.
REQ-015 misr_sig  output  DATA_W  current MISR contents, for debug readout.

Function
REQ-016 FSM states SHALL be IDLE, READ, DRAIN, CHECK, DONE.
REQ-017 IDLE->READ SHALL occur on the cycle after a bist_start rising edge is sampled while bist_en=1; MISR SHALL be seeded to all-ones on that transition.
REQ-018 In READ, rom_ren SHALL be 1 and rom_addr SHALL step 0,1,...,2^ADDR_W-1, one address per cycle, with no gaps.
REQ-019 READ->DRAIN SHALL occur after the cycle that issues the last address; the address counter SHALL NOT wrap to 0 inside READ.
REQ-020 A RD_LAT-deep valid shift pipe SHALL mark returning data; the MISR SHALL update only on cycles where the pipe output is valid.
REQ-021 MISR update: next = {misr[DATA_W-2:0],1'b0} XOR (misr[DATA_W-1] ? 32'h04C11DB7 : 0) XOR rom_rdata.
REQ-022 DRAIN SHALL last exactly RD_LAT cycles, with rom_ren=0, then go to CHECK.
REQ-023 CHECK SHALL last one cycle and register the comparison misr==EXP_SIG into bist_pass; the FSM then goes to DONE.
REQ-024 DONE SHALL hold bist_done=1 and bist_pass stable until bist_en=0, then go to IDLE and clear bist_done and bist_pass.
REQ-025 bist_busy SHALL be 1 in READ, DRAIN and CHECK, and 0 otherwise.
REQ-026 bist_start edges SHALL be ignored while bist_busy=1 or while in DONE.
REQ-027 If bist_en falls in READ, DRAIN or CHECK, the FSM SHALL return to IDLE next cycle with rom_ren=0, the valid pipe flushed, bist_done=0 and bist_pass=0.
REQ-028 A bist_start edge coincident with bist_en=0 SHALL be ignored.
REQ-029 rom_addr SHALL read 0 whenever rom_ren=0.
REQ-030 Run latency with the default parameters: bist_done SHALL rise 2^ADDR_W+RD_LAT+2 cycles after the cycle in which the start edge is sampled.

Reset
REQ-031 While rstb=0 the block SHALL be held as follows: FSM=IDLE, rom_ren=0, rom_addr=0, bist_busy=0, bist_done=0, bist_pass=0, misr_sig=0, valid pipe cleared, start-edge register=0.
REQ-032 Reset assertion mid-run SHALL abort immediately and asynchronously to the REQ-031 values.
REQ-033 Reset deassertion SHALL be synchronous to clk via the existing reset-synchronizer macro.
REQ-034 No start SHALL be accepted in the first cycle after reset release.

Structure
REQ-035 Package rom_bist_pkg SHALL hold the FSM state enum, the MISR polynomial constant and the MISR seed constant.
REQ-036 The MISR SHALL be a sub-module rom_bist_misr with ports clk, rstb, seed, en, din and sig.
REQ-037 rom_bist_ctrl SHALL contain the FSM, the address counter, the valid pipe and the start-edge detector.

Verification
REQ-038 Good ROM image: EXP_SIG=model signature, start pulse -> 2048 consecutive rom_ren cycles with addr 0..2047, then bist_done=1 at cycle 2051 (RD_LAT=1) and bist_pass=1.
REQ-039 Corrupt ROM: flip bit 0 of word 1000 -> bist_done=1 with bist_pass=0, and misr_sig differs from EXP_SIG.
REQ-040 Abort: drop bist_en at addr 500 -> next cycle IDLE, rom_ren=0, bist_busy=0, bist_done=0; a re-run then passes.
REQ-041 Latency sweep: RD_LAT=3 -> DRAIN lasts 3 cycles, bist_done at cycle 2053, signature matches the RD_LAT=1 run.
REQ-042 Reset mid-DRAIN: rstb=0 -> all outputs at their REQ-031 values within the same cycle; a start in the first cycle after release is ignored.
REQ-043 Second start pulse during READ and during DONE -> no effect; addresses remain monotonic and bist_done stays 1 until bist_en=0.
